// File: rtl/fft_sink_framer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fft_sink_framer_pkg                                             |
// | Purpose  : Shared types and helpers for the FFT sink framer.               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package fft_sink_framer_pkg;

    localparam int SKID_DEPTH = 2;
    localparam int COMP_W     = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } t_framer_state;

    typedef struct packed {
        logic [COMP_W-1:0] re;
        logic [COMP_W-1:0] im;
    } t_sample;

    // Buffer words carry the real part in the upper half.
    function automatic t_sample split_sample(input logic [2*COMP_W-1:0] word);
        t_sample s;
        s.re = word[2*COMP_W-1:COMP_W];
        s.im = word[COMP_W-1:0];
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_sink_skid_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fft_sink_skid_fifo                                              |
// | Purpose  : 2-entry, 64-bit skid FIFO with occupancy and synchronous flush. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module fft_sink_skid_fifo
    import fft_sink_framer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        push,
    input  logic [63:0] push_data,
    input  logic        pop,
    output logic [63:0] head,
    output logic [1:0]  occupancy
);

    logic [63:0] r_mem [SKID_DEPTH];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(push) - 2'(pop);
        end
    end

    assign head      = r_mem[r_rd_ptr];
    assign occupancy = r_count;

endmodule
`default_nettype wire

// File: rtl/fft_sink_framer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fft_sink_framer                                                 |
// | Purpose  : Frames read-buffer samples into Avalon-ST FFT sink packets.     |
// |            Optional starvation timeout: FFT_SINK_FRAMER_TIMEOUT_EN.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module fft_sink_framer
    import fft_sink_framer_pkg::*;
#(
    parameter int FFTPTS_W       = 11,
    parameter int SAMPLE_W       = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic [63:0]         data_length,
    input  logic [FFTPTS_W-1:0] fft_pts,
    input  logic                inverse_in,
    output logic                done,
    output logic                busy,
    output logic                timeout_err,
    input  logic [63:0]         buf_data,
    input  logic                buf_empty,
    output logic                buf_rd_enable,
    output logic                sink_valid,
    input  logic                sink_ready,
    output logic                sink_sop,
    output logic                sink_eop,
    output logic [1:0]          sink_error,
    output logic [SAMPLE_W-1:0] sink_real,
    output logic [SAMPLE_W-1:0] sink_imag,
    output logic [FFTPTS_W-1:0] fftpts_in,
    output logic                inverse
);

    t_framer_state       r_state;
    logic [63:0]         r_len;
    logic [63:0]         r_rd_cnt;
    logic [63:0]         r_sent_cnt;
    logic [FFTPTS_W-1:0] r_pts;
    logic [FFTPTS_W-1:0] r_pt_cnt;
    logic                r_inverse;
    logic                r_inflight;
    logic                r_done;

    logic [63:0] w_head;
    logic [1:0]  w_occ;
    logic [2:0]  w_credit;
    logic        w_accept;
    logic        w_pop;
    logic        w_start;
    logic        w_last;
    logic        w_timeout;
    t_sample     w_smp;

    assign w_accept = sink_valid && sink_ready;
    assign w_start  = (r_state == IDLE) && run && !r_done;
    assign w_last   = w_accept && (r_sent_cnt == r_len - 64'd1);

    // Slots still claimed after this cycle: lets a full-rate stream refill the
    // slot that the sink frees in the same cycle without ever overrunning.
    assign w_credit = {1'b0, w_occ} + {2'b0, r_inflight} - {2'b0, w_accept};
    assign w_pop    = (r_state == STREAM) && !buf_empty && (r_rd_cnt < r_len)
                      && (w_credit < 3'd2);

    fft_sink_skid_fifo u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (w_timeout),
        .push      (r_inflight),
        .push_data (buf_data),
        .pop       (w_accept),
        .head      (w_head),
        .occupancy (w_occ)
    );

    assign w_smp         = split_sample(w_head);
    assign sink_valid    = (w_occ != 2'd0);
    assign sink_sop      = sink_valid && (r_pt_cnt == '0);
    assign sink_eop      = sink_valid && ((r_pt_cnt == r_pts - FFTPTS_W'(1))
                                          || (r_sent_cnt == r_len - 64'd1));
    assign sink_error    = 2'b00;
    assign sink_real     = w_smp.re;
    assign sink_imag     = w_smp.im;
    assign buf_rd_enable = w_pop;
    assign busy          = (r_state != IDLE);
    assign done          = r_done;
    assign fftpts_in     = r_pts;
    assign inverse       = r_inverse;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_len      <= '0;
            r_pts      <= '0;
            r_inverse  <= 1'b0;
            r_rd_cnt   <= '0;
            r_sent_cnt <= '0;
            r_pt_cnt   <= '0;
            r_inflight <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_inflight <= w_pop;
            if (w_pop) begin
                r_rd_cnt <= r_rd_cnt + 64'd1;
            end
            if (w_accept) begin
                r_sent_cnt <= r_sent_cnt + 64'd1;
                r_pt_cnt   <= sink_eop ? '0 : r_pt_cnt + FFTPTS_W'(1);
            end
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_len      <= data_length;
                        r_pts      <= fft_pts;
                        r_inverse  <= inverse_in;
                        r_rd_cnt   <= '0;
                        r_sent_cnt <= '0;
                        r_pt_cnt   <= '0;
                        if (data_length == 64'd0 || fft_pts == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= STREAM;
                        end
                    end
                end
                STREAM, DRAIN: begin
                    if (w_timeout) begin
                        r_state  <= IDLE;
                        r_done   <= 1'b1;
                        r_pt_cnt <= '0;
                    end else if (w_last) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end else if (r_state == STREAM && r_rd_cnt == r_len) begin
                        r_state <= DRAIN;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef FFT_SINK_FRAMER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_starve;
    logic            r_timeout_err;
    logic            w_starving;

    assign w_starving = busy && (r_pt_cnt != '0) && (w_occ == 2'd0) && buf_empty;
    assign w_timeout  = w_starving && (r_starve == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (!w_starving || w_accept || w_pop || w_timeout) begin
                r_starve <= '0;
            end else begin
                r_starve <= r_starve + TO_W'(1);
            end
            if (w_start) begin
                r_timeout_err <= 1'b0;
            end else if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    logic w_unused_timeout_cfg;

    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign w_timeout            = 1'b0;
    assign timeout_err          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fft_sink_framer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fft_sink_framer                                              |
// | Purpose  : Self-checking bench for fft_sink_framer with frame model.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_fft_sink_framer;

    localparam int TO_CYC = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [63:0] data_length;
    logic [10:0] fft_pts;
    logic        inverse_in;
    logic        done, busy, timeout_err;
    logic [63:0] buf_data = '0;
    logic        buf_empty = 1'b1;
    logic        buf_rd_enable;
    logic        sink_valid, sink_ready, sink_sop, sink_eop;
    logic [1:0]  sink_error;
    logic [31:0] sink_real, sink_imag;
    logic [10:0] fftpts_in;
    logic        inverse;

    int checks = 0;
    int errors = 0;

    fft_sink_framer #(.FFTPTS_W(11), .SAMPLE_W(32), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk(clk), .reset(reset), .run(run), .data_length(data_length),
        .fft_pts(fft_pts), .inverse_in(inverse_in), .done(done), .busy(busy),
        .timeout_err(timeout_err), .buf_data(buf_data), .buf_empty(buf_empty),
        .buf_rd_enable(buf_rd_enable), .sink_valid(sink_valid), .sink_ready(sink_ready),
        .sink_sop(sink_sop), .sink_eop(sink_eop), .sink_error(sink_error),
        .sink_real(sink_real), .sink_imag(sink_imag), .fftpts_in(fftpts_in),
        .inverse(inverse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Read-buffer model: data appears one cycle after each pop.
    logic [63:0] bq[$];
    int pops = 0;
    int underflows = 0;
    always @(posedge clk) begin
        if (buf_rd_enable) begin
            if (bq.size() == 0) underflows++;
            else buf_data <= bq.pop_front();
            pops++;
        end
        buf_empty <= (bq.size() == 0);
    end

    int rdy_mode = 0;
    initial begin
        sink_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       sink_ready = ~sink_ready;
                2:       sink_ready = ($urandom_range(0, 9) < 7);
                default: sink_ready = 1'b1;
            endcase
        end
    end

    // Frame model: beat k is sample k; frame position is k mod points.
    logic [63:0] exp_q[$];
    int job_len = 0, job_pts = 1;
    int beat_idx = 0, done_cnt = 0;
    int cyc = 0, run_cyc = 0, done_cyc = 0, first_cyc = 0, last_cyc = 0;
    bit hold_prev = 0;
    logic [63:0] prev_data;
    logic prev_sop, prev_eop;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            hold_prev = 0;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", 64'(sink_valid), 64'd1);
                chk("hold_data", {sink_real, sink_imag}, prev_data);
                chk("hold_sop", 64'(sink_sop), 64'(prev_sop));
                chk("hold_eop", 64'(sink_eop), 64'(prev_eop));
            end
            if (run) run_cyc = cyc;
            if (sink_valid && sink_ready) begin
                if (beat_idx >= exp_q.size()) begin
                    chk("beat_extra", 64'(beat_idx), 64'(exp_q.size()));
                end else begin
                    chk("beat_data", {sink_real, sink_imag}, exp_q[beat_idx]);
                    chk("beat_sop", 64'(sink_sop), 64'((beat_idx % job_pts) == 0));
                    chk("beat_eop", 64'(sink_eop),
                        64'(((beat_idx % job_pts) == job_pts - 1) || (beat_idx == job_len - 1)));
                    chk("beat_err", 64'(sink_error), 64'd0);
                end
                if (beat_idx == 0) first_cyc = cyc;
                last_cyc = cyc;
                beat_idx++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            hold_prev = sink_valid && !sink_ready;
            prev_data = {sink_real, sink_imag};
            prev_sop  = sink_sop;
            prev_eop  = sink_eop;
        end
    end

    int done_base = 0;
    int job_eff = 0;

    task automatic start_job(input int len, input int pts, input bit inv, input int mode,
                             input int avail);
        logic [63:0] v;
        job_eff = (len == 0 || pts == 0) ? 0 : len;
        bq.delete();
        exp_q.delete();
        for (int i = 0; i < avail; i++) begin
            v = {$urandom, $urandom};
            bq.push_back(v);
            exp_q.push_back(v);
        end
        job_len = len;
        job_pts = (pts == 0) ? 1 : pts;
        beat_idx = 0;
        pops = 0;
        underflows = 0;
        done_base = done_cnt;
        rdy_mode = mode;
        repeat (2) @(posedge clk);
        #1;
        data_length = 64'(len);
        fft_pts = 11'(pts);
        inverse_in = inv;
        run = 1'b1;
        @(posedge clk);
        #1;
        run = 1'b0;
        chk("busy_after_run", 64'(busy), 64'(job_eff > 0));
        chk("fftpts_latched", 64'(fftpts_in), 64'(pts));
        chk("inverse_latched", 64'(inverse), 64'(inv));
        chk("timeout_clr_on_run", 64'(timeout_err), 64'd0);
    endtask

    task automatic finish_job();
        for (int i = 0; i < job_eff * 20 + 100 && done_cnt == done_base; i++) @(negedge clk);
        chk("job_done", 64'(done_cnt - done_base), 64'd1);
        repeat (3) @(negedge clk);
        chk("done_single", 64'(done_cnt - done_base), 64'd1);
        chk("beats_sent", 64'(beat_idx), 64'(job_eff));
        chk("buf_pops", 64'(pops), 64'(job_eff));
        chk("buf_underflow", 64'(underflows), 64'd0);
        chk("busy_end", 64'(busy), 64'd0);
        if (job_eff > 0) chk("done_latency", 64'(done_cyc - last_cyc), 64'd1);
        else chk("zero_done_latency", 64'(done_cyc - run_cyc), 64'd1);
    endtask

    task automatic run_job(input int len, input int pts, input bit inv, input int mode);
        start_job(len, pts, inv, mode, (len == 0 || pts == 0) ? 0 : len);
        finish_job();
    endtask

    initial begin
        reset = 1'b0;
        run = 1'b0;
        data_length = '0;
        fft_pts = '0;
        inverse_in = 1'b0;
        #1 reset = 1'b1;
        #2;
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(sink_valid), 64'd0);
        chk("rst_sop", 64'(sink_sop), 64'd0);
        chk("rst_eop", 64'(sink_eop), 64'd0);
        chk("rst_rd_en", 64'(buf_rd_enable), 64'd0);
        chk("rst_data", {sink_real, sink_imag}, 64'd0);
        chk("rst_fftpts", 64'(fftpts_in), 64'd0);
        chk("rst_timeout", 64'(timeout_err), 64'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        run_job(8, 4, 1'b0, 0);
        chk("t1_back_to_back", 64'(last_cyc - first_cyc), 64'd7);
        run_job(4, 4, 1'b1, 1);
        run_job(6, 4, 1'b0, 0);
        run_job(0, 4, 1'b0, 0);
        run_job(5, 0, 1'b1, 0);

        start_job(12, 5, 1'b1, 2, 12);
        repeat (3) @(posedge clk);
        #1;
        fft_pts = 11'd3;
        inverse_in = 1'b0;
        run = 1'b1;
        @(posedge clk);
        #1;
        run = 1'b0;
        chk("run_ignored_pts", 64'(fftpts_in), 64'd5);
        chk("run_ignored_inv", 64'(inverse), 64'd1);
        finish_job();

        start_job(4, 4, 1'b0, 0, 4);
        for (int i = 0; i < 50 && beat_idx < 2; i++) @(posedge clk);
        chk("t5_reached_beat2", 64'(beat_idx), 64'd2);
        #2 reset = 1'b1;
        #1;
        chk("midrst_valid", 64'(sink_valid), 64'd0);
        chk("midrst_sop", 64'(sink_sop), 64'd0);
        chk("midrst_eop", 64'(sink_eop), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_rd_en", 64'(buf_rd_enable), 64'd0);
        chk("midrst_data", {sink_real, sink_imag}, 64'd0);
        chk("midrst_fftpts", 64'(fftpts_in), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        bq.delete();
        exp_q.delete();
        beat_idx = 0;
        run_job(4, 4, 1'b0, 0);

        for (int j = 0; j < 6; j++) begin
            run_job($urandom_range(1, 40), $urandom_range(1, 12), 1'($urandom_range(0, 1)), 2);
        end

`ifdef FFT_SINK_FRAMER_TIMEOUT_EN
        start_job(4, 4, 1'b0, 0, 2);
        for (int i = 0; i < 200 && done_cnt == done_base; i++) @(negedge clk);
        chk("to_done", 64'(done_cnt - done_base), 64'd1);
        chk("to_err", 64'(timeout_err), 64'd1);
        chk("to_busy", 64'(busy), 64'd0);
        chk("to_beats", 64'(beat_idx), 64'd2);
        chk("to_latency_window",
            64'((done_cyc - last_cyc >= TO_CYC) && (done_cyc - last_cyc <= TO_CYC + 2)), 64'd1);
        run_job(4, 4, 1'b0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
